// File: rtl/game_pkg.sv
// game_pkg: shared encodings and helpers for the game playfield logic.
package game_pkg;

    localparam int unsigned COORD_W       = 10;
    localparam int unsigned SCREEN_W_DFLT = 640;
    localparam int unsigned SCREEN_H_DFLT = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        MODE_DIAG   = 2'b00,
        MODE_HORIZ  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_ALIVE = 1'b1
    } chan_state_e;

    // x^10 + x^7 + 1 Fibonacci step
    function automatic coord_t lfsr10_next(input coord_t v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    // unsigned range test; a wrapped underflow lands high and is caught by hi
    function automatic logic coord_oor(input coord_t v, input coord_t lo, input coord_t hi);
        return (v < lo) || (v >= hi);
    endfunction

endpackage

// File: rtl/lfsr10.sv
// lfsr10: free-running 10-bit LFSR, advances every clock, reloads SEED on reset.
module lfsr10
    import game_pkg::*;
#(
    parameter logic [9:0] SEED = 10'h001
) (
    input  logic       clk_22,
    input  logic       rst,
    output logic [9:0] q
);

    coord_t q_q, q_d;

    // next value
    always_comb begin
        q_d = lfsr10_next(q_q);
    end

    // state register
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) q_q <= SEED;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/enemy_swarm_mover.sv
// enemy_swarm_mover: N_ENEMY independent enemy sprites with LFSR-driven motion,
// edge death, kill handling and timed respawn into a random spawn region.
// Optional feature macro: ENEMY_BOUNCE_EN (mode 10 reflects off edges with
// per-channel velocity signs; when undefined mode 10 behaves as mode 00).
module enemy_swarm_mover
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY    = 4,
    parameter int unsigned SCREEN_W   = SCREEN_W_DFLT,
    parameter int unsigned SCREEN_H   = SCREEN_H_DFLT,
    parameter int unsigned MARGIN     = 3,
    parameter int unsigned STEP       = 5,
    parameter int unsigned RESPAWN_CD = 100,
    parameter int unsigned SPAWN_X0   = 450,
    parameter int unsigned SPAWN_XW   = 200,
    parameter int unsigned SPAWN_Y0   = 160,
    parameter int unsigned SPAWN_YW   = 320,
    parameter int unsigned INIT_X     = 560,
    parameter int unsigned INIT_Y     = 60,
    parameter int unsigned INIT_DY    = 48
) (
    input  logic                          clk_22,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [1:0]                    mode,
    input  logic [N_ENEMY-1:0]            kill,
    output logic [COORD_W*N_ENEMY-1:0]    pos_x,
    output logic [COORD_W*N_ENEMY-1:0]    pos_y,
    output logic [N_ENEMY-1:0]            alive,
    output logic [N_ENEMY-1:0]            respawn,
    output logic [7:0]                    kill_count
);

    localparam int unsigned     CD_W     = (RESPAWN_CD > 1) ? $clog2(RESPAWN_CD) : 1;
    localparam logic [CD_W-1:0] CD_LAST  = CD_W'(RESPAWN_CD - 1);
    localparam coord_t          C_STEP   = COORD_W'(STEP);
    localparam coord_t          C_MARGIN = COORD_W'(MARGIN);
    localparam coord_t          C_SW     = COORD_W'(SCREEN_W);
    localparam coord_t          C_SH     = COORD_W'(SCREEN_H);

    coord_t               lfsr_x, lfsr_y, lfsr_dir;
    coord_t               spawn_x_c, spawn_y_c;
    logic [N_ENEMY-1:0]   kill_acc_c;
    logic                 lfsr_unused_c;
    logic [7:0]           kc_q, kc_d;
    logic [8:0]           kc_sum_c;

    lfsr10 #(.SEED(10'h043)) u_lfsr_x   (.clk_22(clk_22), .rst(rst), .q(lfsr_x));
    lfsr10 #(.SEED(10'h0C9)) u_lfsr_y   (.clk_22(clk_22), .rst(rst), .q(lfsr_y));
    lfsr10 #(.SEED(10'h1A5)) u_lfsr_dir (.clk_22(clk_22), .rst(rst), .q(lfsr_dir));

    // only the low N_ENEMY direction bits steer channels
    assign lfsr_unused_c = ^lfsr_dir;

    // spawn point shared by every channel respawning this cycle
    assign spawn_x_c = COORD_W'(SPAWN_X0 + (32'(lfsr_x) % SPAWN_XW));
    assign spawn_y_c = COORD_W'(SPAWN_Y0 + (32'(lfsr_y) % SPAWN_YW));

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_ch
        chan_state_e     state_q, state_d;
        coord_t          x_q, x_d, y_q, y_d;
        coord_t          nx_c, ny_c, x_m_c, y_m_c, y_p_c;
        logic [CD_W-1:0] cd_q, cd_d;
        logic            resp_q, resp_d;
        logic            die_c, acc_c;
`ifdef ENEMY_BOUNCE_EN
        coord_t          x_p_c;
        logic            sx_q, sx_d, sy_q, sy_d, sx_n_c, sy_n_c;
        assign x_p_c = x_q + C_STEP;
`endif

        assign x_m_c = x_q - C_STEP;
        assign y_m_c = y_q - C_STEP;
        assign y_p_c = y_q + C_STEP;

        // candidate position for this tick and whether it leaves the screen
        always_comb begin
            nx_c  = x_q;
            ny_c  = y_q;
            die_c = 1'b0;
`ifdef ENEMY_BOUNCE_EN
            sx_n_c = sx_q;
            sy_n_c = sy_q;
`endif
            case (mode_e'(mode))
                MODE_DIAG: begin
                    nx_c  = x_m_c;
                    ny_c  = lfsr_dir[gi] ? y_p_c : y_m_c;
                    die_c = coord_oor(nx_c, C_MARGIN, C_SW) || coord_oor(ny_c, C_MARGIN, C_SH);
                end
                MODE_HORIZ: begin
                    nx_c  = x_m_c;
                    die_c = coord_oor(nx_c, C_MARGIN, C_SW);
                end
                MODE_BOUNCE: begin
`ifdef ENEMY_BOUNCE_EN
                    nx_c = sx_q ? x_p_c : x_m_c;
                    if (coord_oor(nx_c, C_MARGIN, C_SW)) begin
                        sx_n_c = ~sx_q;
                        nx_c   = sx_q ? x_m_c : x_p_c;
                    end
                    ny_c = sy_q ? y_p_c : y_m_c;
                    if (coord_oor(ny_c, C_MARGIN, C_SH)) begin
                        sy_n_c = ~sy_q;
                        ny_c   = sy_q ? y_m_c : y_p_c;
                    end
`else
                    nx_c  = x_m_c;
                    ny_c  = lfsr_dir[gi] ? y_p_c : y_m_c;
                    die_c = coord_oor(nx_c, C_MARGIN, C_SW) || coord_oor(ny_c, C_MARGIN, C_SH);
`endif
                end
                default: ;
            endcase
        end

        // ALIVE/DEAD next state; kill outranks an edge exit
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_ALIVE: if (kill[gi] || (tick && die_c)) state_d = ST_DEAD;
                ST_DEAD:  if (tick && (cd_q == CD_LAST)) state_d = ST_ALIVE;
                default:  state_d = ST_ALIVE;
            endcase
        end

        // position, cooldown, respawn strobe and kill acceptance
        always_comb begin
            x_d    = x_q;
            y_d    = y_q;
            cd_d   = cd_q;
            resp_d = 1'b0;
            acc_c  = 1'b0;
`ifdef ENEMY_BOUNCE_EN
            sx_d = sx_q;
            sy_d = sy_q;
`endif
            case (state_q)
                ST_ALIVE: begin
                    if (kill[gi]) begin
                        acc_c = 1'b1;
                        cd_d  = '0;
                    end else if (tick && die_c) begin
                        cd_d = '0;
                    end else if (tick) begin
                        x_d = nx_c;
                        y_d = ny_c;
`ifdef ENEMY_BOUNCE_EN
                        sx_d = sx_n_c;
                        sy_d = sy_n_c;
`endif
                    end
                end
                ST_DEAD: begin
                    if (tick) begin
                        if (cd_q == CD_LAST) begin
                            x_d    = spawn_x_c;
                            y_d    = spawn_y_c;
                            resp_d = 1'b1;
                            cd_d   = '0;
                        end else begin
                            cd_d = cd_q + CD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // channel registers
        always_ff @(posedge clk_22 or posedge rst) begin
            if (rst) begin
                state_q <= ST_ALIVE;
                x_q     <= COORD_W'(INIT_X);
                y_q     <= COORD_W'(INIT_Y + gi * INIT_DY);
                cd_q    <= '0;
                resp_q  <= 1'b0;
`ifdef ENEMY_BOUNCE_EN
                sx_q    <= 1'b0;
                sy_q    <= 1'b1;
`endif
            end else begin
                state_q <= state_d;
                x_q     <= x_d;
                y_q     <= y_d;
                cd_q    <= cd_d;
                resp_q  <= resp_d;
`ifdef ENEMY_BOUNCE_EN
                sx_q    <= sx_d;
                sy_q    <= sy_d;
`endif
            end
        end

        assign kill_acc_c[gi]                = acc_c;
        assign pos_x[COORD_W*gi +: COORD_W]  = x_q;
        assign pos_y[COORD_W*gi +: COORD_W]  = y_q;
        assign alive[gi]                     = (state_q == ST_ALIVE);
        assign respawn[gi]                   = resp_q;
    end

    // saturating sum of kills accepted this cycle
    always_comb begin
        kc_sum_c = {1'b0, kc_q};
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            kc_sum_c = kc_sum_c + 9'(kill_acc_c[i]);
        end
        kc_d = (kc_sum_c > 9'd255) ? 8'hFF : kc_sum_c[7:0];
    end

    // kill counter register
    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) kc_q <= 8'h00;
        else     kc_q <= kc_d;
    end

    assign kill_count = kc_q;

endmodule

// File: tb/tb_enemy_swarm_mover.sv
// tb_enemy_swarm_mover: directed bench for enemy_swarm_mover (default parameters).
module tb_enemy_swarm_mover;

    logic        clk_22 = 1'b0;
    logic        rst;
    logic        tick;
    logic [1:0]  mode;
    logic [3:0]  kill;
    logic [39:0] pos_x, pos_y;
    logic [3:0]  alive, respawn;
    logic [7:0]  kill_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [9:0] lx, ly, ld;
    int  mx[4], my[4], mcd[4], mkc;
    bit  ma[4], mr[4], msx[4], msy[4];

    enemy_swarm_mover dut (
        .clk_22(clk_22), .rst(rst), .tick(tick), .mode(mode), .kill(kill),
        .pos_x(pos_x), .pos_y(pos_y), .alive(alive), .respawn(respawn),
        .kill_count(kill_count)
    );

    always #5 clk_22 = ~clk_22;

    function automatic logic [9:0] lstep(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic bit oor(input int v, input int lim);
        return (v < 3) || (v >= lim);
    endfunction

    function automatic logic [3:0] m_alive();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ma[i];
        return r;
    endfunction

    task automatic model_reset();
        lx = 10'h043; ly = 10'h0C9; ld = 10'h1A5; mkc = 0;
        for (int i = 0; i < 4; i++) begin
            mx[i] = 560; my[i] = 60 + 48 * i; ma[i] = 1; mr[i] = 0;
            mcd[i] = 0; msx[i] = 0; msy[i] = 1;
        end
    endtask

    // drive one cycle at the falling edge, advance the reference, return at next falling edge
    task automatic cyc(input bit t, input logic [1:0] m, input logic [3:0] k);
        int nx, ny; bit sx, sy, die;
        tick = t; mode = m; kill = k;
        for (int i = 0; i < 4; i++) begin
            mr[i] = 0;
            if (ma[i]) begin
                if (k[i]) begin
                    ma[i] = 0; mcd[i] = 0;
                    if (mkc < 255) mkc++;
                end else if (t) begin
                    nx = mx[i]; ny = my[i]; sx = msx[i]; sy = msy[i]; die = 0;
                    if (m == 2'b00 || m == 2'b01) begin
                        nx = (mx[i] - 5) & 1023;
                        if (m == 2'b00) ny = ld[i] ? ((my[i] + 5) & 1023) : ((my[i] - 5) & 1023);
                        die = oor(nx, 640) || oor(ny, 480);
                    end else if (m == 2'b10) begin
`ifdef ENEMY_BOUNCE_EN
                        nx = msx[i] ? ((mx[i] + 5) & 1023) : ((mx[i] - 5) & 1023);
                        if (oor(nx, 640)) begin
                            sx = !msx[i];
                            nx = sx ? ((mx[i] + 5) & 1023) : ((mx[i] - 5) & 1023);
                        end
                        ny = msy[i] ? ((my[i] + 5) & 1023) : ((my[i] - 5) & 1023);
                        if (oor(ny, 480)) begin
                            sy = !msy[i];
                            ny = sy ? ((my[i] + 5) & 1023) : ((my[i] - 5) & 1023);
                        end
`else
                        nx = (mx[i] - 5) & 1023;
                        ny = ld[i] ? ((my[i] + 5) & 1023) : ((my[i] - 5) & 1023);
                        die = oor(nx, 640) || oor(ny, 480);
`endif
                    end
                    if (die) begin
                        ma[i] = 0; mcd[i] = 0;
                    end else begin
                        mx[i] = nx; my[i] = ny; msx[i] = sx; msy[i] = sy;
                    end
                end
            end else if (t) begin
                if (mcd[i] == 99) begin
                    mx[i] = 450 + (int'(lx) % 200);
                    my[i] = 160 + (int'(ly) % 320);
                    ma[i] = 1; mr[i] = 1; mcd[i] = 0;
                end else begin
                    mcd[i]++;
                end
            end
        end
        @(posedge clk_22);
        lx = lstep(lx); ly = lstep(ly); ld = lstep(ld);
        @(negedge clk_22);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; mode = 2'b00; kill = 4'b0;
        repeat (2) @(negedge clk_22);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (alive !== 4'hF) begin n_bad++; $display("FAIL reset_alive: got %h want %h", alive, 4'hF); end
        n_cmp++; if (pos_x[19:10] !== 10'd560 || pos_y[19:10] !== 10'd108) begin
            n_bad++; $display("FAIL reset_ch1_pos: got (%0d,%0d) want (560,108)", pos_x[19:10], pos_y[19:10]); end
        n_cmp++; if (pos_y[9:0] !== 10'd60 || pos_y[39:30] !== 10'd204) begin
            n_bad++; $display("FAIL reset_y: got ch0 %0d ch3 %0d want 60 204", pos_y[9:0], pos_y[39:30]); end
        n_cmp++; if (kill_count !== 8'd0) begin n_bad++; $display("FAIL reset_kc: got %0d want 0", kill_count); end
        n_cmp++; if (respawn !== 4'h0) begin n_bad++; $display("FAIL reset_respawn: got %h want 0", respawn); end
    endtask

    // ten ticks placed only on cycles where direction bit 0 is set
    task automatic test_diag();
        int cnt = 0;
        for (int g = 0; g < 400 && cnt < 10; g++) begin
            if (ld[0]) begin cyc(1'b1, 2'b00, 4'b0); cnt++; end
            else cyc(1'b0, 2'b00, 4'b0);
        end
        n_cmp++; if (cnt != 10) begin n_bad++; $display("FAIL diag_timeout: got %0d ticks want 10", cnt); end
        n_cmp++; if (pos_x[9:0] !== 10'd510 || pos_y[9:0] !== 10'd110 || alive[0] !== 1'b1) begin
            n_bad++; $display("FAIL diag_ch0: got (%0d,%0d,a=%b) want (510,110,a=1)", pos_x[9:0], pos_y[9:0], alive[0]); end
        n_cmp++; if (pos_x[19:10] !== 10'd510 || pos_y[19:10] !== 10'(my[1])) begin
            n_bad++; $display("FAIL diag_ch1: got (%0d,%0d) want (510,%0d)", pos_x[19:10], pos_y[19:10], my[1]); end
        n_cmp++; if (alive !== m_alive()) begin n_bad++; $display("FAIL diag_alive: got %h want %h", alive, m_alive()); end
    endtask

    task automatic test_kill_respawn();
        cyc(1'b0, 2'b11, 4'b0001);
        n_cmp++; if (alive[0] !== 1'b0 || kill_count !== 8'd1) begin
            n_bad++; $display("FAIL kill_ch0: got a=%b kc=%0d want a=0 kc=1", alive[0], kill_count); end
        for (int t = 1; t <= 100; t++) begin
            cyc(1'b1, 2'b11, (t == 50) ? 4'b0001 : 4'b0000);
            if (t == 99) begin
                n_cmp++; if (alive[0] !== 1'b0 || respawn[0] !== 1'b0) begin
                    n_bad++; $display("FAIL cd_early: got a=%b r=%b at tick 99 want 0 0", alive[0], respawn[0]); end
            end
        end
        n_cmp++; if (alive[0] !== 1'b1 || respawn[0] !== 1'b1) begin
            n_bad++; $display("FAIL respawn_edge: got a=%b r=%b want 1 1", alive[0], respawn[0]); end
        n_cmp++; if (pos_x[9:0] < 10'd450 || pos_x[9:0] > 10'd649 || pos_y[9:0] < 10'd160 || pos_y[9:0] > 10'd479) begin
            n_bad++; $display("FAIL spawn_range: got (%0d,%0d)", pos_x[9:0], pos_y[9:0]); end
        n_cmp++; if (pos_x[9:0] !== 10'(mx[0]) || pos_y[9:0] !== 10'(my[0])) begin
            n_bad++; $display("FAIL spawn_pos: got (%0d,%0d) want (%0d,%0d)", pos_x[9:0], pos_y[9:0], mx[0], my[0]); end
        n_cmp++; if (kill_count !== 8'd1) begin n_bad++; $display("FAIL dead_kill_ignored: got %0d want 1", kill_count); end
        cyc(1'b0, 2'b11, 4'b0);
        n_cmp++; if (respawn !== 4'h0 || alive[0] !== 1'b1) begin
            n_bad++; $display("FAIL respawn_pulse: got r=%h a0=%b want r=0 a0=1", respawn, alive[0]); end
    endtask

    task automatic test_horiz_edge();
        for (int g = 0; g < 300 && ma[0]; g++) cyc(1'b1, 2'b01, 4'b0);
        n_cmp++; if (alive[0] !== 1'b0 || ma[0]) begin n_bad++; $display("FAIL horiz_death: got a0=%b want 0", alive[0]); end
        n_cmp++; if (pos_x[9:0] !== 10'(mx[0]) || pos_y[9:0] !== 10'(my[0])) begin
            n_bad++; $display("FAIL horiz_hold: got (%0d,%0d) want (%0d,%0d)", pos_x[9:0], pos_y[9:0], mx[0], my[0]); end
        n_cmp++; if (kill_count !== 8'd1) begin n_bad++; $display("FAIL horiz_kc: got %0d want 1", kill_count); end
    endtask

    task automatic test_bounce();
        bit seen_dead = 0;
        do_reset();
        for (int k = 1; k <= 178; k++) begin
            cyc(1'b1, 2'b10, 4'b0);
            if (!alive[0]) seen_dead = 1;
`ifdef ENEMY_BOUNCE_EN
            if (k == 112) begin
                n_cmp++; if (pos_x[9:0] !== 10'd10 || pos_y[9:0] !== 10'd330) begin
                    n_bad++; $display("FAIL bounce_x: got (%0d,%0d) want (10,330)", pos_x[9:0], pos_y[9:0]); end
            end
            if (k == 177) begin
                n_cmp++; if (pos_x[9:0] !== 10'd335 || pos_y[9:0] !== 10'd5) begin
                    n_bad++; $display("FAIL bounce_pre: got (%0d,%0d) want (335,5)", pos_x[9:0], pos_y[9:0]); end
            end
            if (k == 178) begin
                n_cmp++; if (pos_x[9:0] !== 10'd340 || pos_y[9:0] !== 10'd10 || alive[0] !== 1'b1) begin
                    n_bad++; $display("FAIL bounce_top: got (%0d,%0d,a=%b) want (340,10,a=1)", pos_x[9:0], pos_y[9:0], alive[0]); end
            end
`endif
        end
`ifdef ENEMY_BOUNCE_EN
        n_cmp++; if (seen_dead) begin n_bad++; $display("FAIL bounce_alive: got a dead cycle want none"); end
`else
        n_cmp++; if (!seen_dead) begin n_bad++; $display("FAIL nobounce_death: got never dead want dead"); end
`endif
        n_cmp++; if (pos_x[9:0] !== 10'(mx[0]) || alive !== m_alive()) begin
            n_bad++; $display("FAIL bounce_model: got x=%0d a=%h want x=%0d a=%h", pos_x[9:0], alive, mx[0], m_alive()); end
        n_cmp++; if (kill_count !== 8'd0) begin n_bad++; $display("FAIL bounce_kc: got %0d want 0", kill_count); end
    endtask

    task automatic test_kill_edge_same();
        do_reset();
        repeat (111) cyc(1'b1, 2'b01, 4'b0);
        n_cmp++; if (pos_x[9:0] !== 10'd5 || alive !== 4'hF) begin
            n_bad++; $display("FAIL edge_setup: got x=%0d a=%h want x=5 a=f", pos_x[9:0], alive); end
        cyc(1'b1, 2'b01, 4'b0001);
        n_cmp++; if (kill_count !== 8'd1) begin n_bad++; $display("FAIL kill_edge_kc: got %0d want 1", kill_count); end
        n_cmp++; if (alive !== 4'h0 || pos_x[9:0] !== 10'd5) begin
            n_bad++; $display("FAIL kill_edge_state: got a=%h x=%0d want a=0 x=5", alive, pos_x[9:0]); end
    endtask

    task automatic test_saturate();
        int acc = 1;
        for (int g = 0; g < 20000 && acc < 300; g++) begin
            acc += $countones(m_alive());
            cyc(1'b1, 2'b11, m_alive());
        end
        cyc(1'b0, 2'b11, 4'b0);
        n_cmp++; if (acc < 300) begin n_bad++; $display("FAIL sat_timeout: got %0d kills want 300", acc); end
        n_cmp++; if (kill_count !== 8'd255) begin n_bad++; $display("FAIL sat_kc: got %0d want 255", kill_count); end
        n_cmp++; if (alive !== m_alive()) begin n_bad++; $display("FAIL sat_alive: got %h want %h", alive, m_alive()); end
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (alive !== 4'hF || kill_count !== 8'd0 || respawn !== 4'h0) begin
            n_bad++; $display("FAIL async_reset: got a=%h kc=%0d r=%h want f 0 0", alive, kill_count, respawn); end
        n_cmp++; if (pos_x[9:0] !== 10'd560 || pos_y[39:30] !== 10'd204) begin
            n_bad++; $display("FAIL async_reset_pos: got x0=%0d y3=%0d want 560 204", pos_x[9:0], pos_y[39:30]); end
        @(negedge clk_22);
        model_reset();
        rst = 1'b0;
        test_diag();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; mode = 2'b00; kill = 4'b0;
        test_reset();
        test_diag();
        test_kill_respawn();
        test_horiz_edge();
        test_bounce();
        test_kill_edge_same();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
